// File: rtl/fallthrough_fifo.sv
// First-word-fall-through FIFO: the head word sits in a register on dout, so no read request is needed to see it.
// Define FALLTHROUGH_FIFO_ERRCHK_EN to build the sticky overflow/underflow flags.
module fallthrough_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      empty,
  output logic [MAX_DEPTH_BITS:0]   data_count,
  output logic                      overflow_err,
  output logic                      underflow_err
);

  localparam int AW    = MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] PROG_C   = CW'(PROG_FULL_THRESHOLD);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             full_reg, nearly_full_reg, empty_reg;
  logic             wr_acc, rd_acc;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign wr_acc     = wr_en && !full_reg;
  assign rd_acc     = rd_en && !empty_reg;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - ONE_C;
    end
  end

  // Next head: word behind the popped one, or din when it lands in an empty
  // (or just-emptied) FIFO; otherwise dout keeps its last value.
  always_comb begin
    dout_next = dout_reg;
    if (rd_acc) begin
      if (count_reg > ONE_C) begin
        dout_next = mem[rd_ptr_inc];
      end else if (wr_acc) begin
        dout_next = din;
      end
    end else if (empty_reg && wr_acc) begin
      dout_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      dout_reg        <= '0;
      full_reg        <= 1'b0;
      nearly_full_reg <= 1'b0;
      empty_reg       <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg       <= count_next;
      dout_reg        <= dout_next;
      full_reg        <= (count_next == DEPTH_C);
      nearly_full_reg <= (count_next >= PROG_C);
      empty_reg       <= (count_next == '0);
    end
  end

`ifdef FALLTHROUGH_FIFO_ERRCHK_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end
      if (rd_en && empty_reg) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

  assign dout        = dout_reg;
  assign full        = full_reg;
  assign nearly_full = nearly_full_reg;
  assign empty       = empty_reg;
  assign data_count  = count_reg;

endmodule

// File: tb/tb_fallthrough_fifo.sv
// Scoreboard bench for fallthrough_fifo: stimulus queues expected words, a negedge monitor checks each pop.
module tb_fallthrough_fifo;

  localparam int WIDTH = 72;
  localparam int MDB   = 3;

`ifdef FALLTHROUGH_FIFO_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] dout;
  logic             full, nearly_full, empty;
  logic [MDB:0]     data_count;
  logic             overflow_err, underflow_err;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q [$];

  fallthrough_fifo #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(MDB)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .nearly_full(nearly_full), .empty(empty),
    .data_count(data_count), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    din   = v;
    wr_en = 1'b1;
    exp_q.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: every accepted pop must present the oldest queued word.
  always @(negedge clk) begin
    if (reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got %0h expected nothing queued", dout);
      end else begin
        check("pop", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] aa;
    aa    = {9{8'hAA}};
    reset = 1'b0;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) tick();
    check("rst_empty", WIDTH'(empty), 1);
    check("rst_full", WIDTH'(full), 0);
    check("rst_nfull", WIDTH'(nearly_full), 0);
    check("rst_count", WIDTH'(data_count), 0);
    check("rst_dout", dout, 0);
    check("rst_ovf", WIDTH'(overflow_err), 0);
    check("rst_unf", WIDTH'(underflow_err), 0);
    reset = 1'b1;
    tick();

    // Single write: visible one cycle later without rd_en.
    push(aa);
    check("wr1_empty", WIDTH'(empty), 0);
    check("wr1_dout", dout, aa);
    check("wr1_count", WIDTH'(data_count), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("rd1_empty", WIDTH'(empty), 1);
    check("hold_dout", dout, aa);

    // Fill to threshold, then to full, then overflow attempt.
    for (int i = 1; i <= 7; i++) push(WIDTH'(i));
    check("f7_nfull", WIDTH'(nearly_full), 1);
    check("f7_full", WIDTH'(full), 0);
    check("f7_count", WIDTH'(data_count), 7);
    push(WIDTH'(8));
    check("f8_full", WIDTH'(full), 1);
    check("f8_count", WIDTH'(data_count), 8);
    din = WIDTH'(9); wr_en = 1'b1; tick(); wr_en = 1'b0;
    check("ovf_count", WIDTH'(data_count), 8);
    check("ovf_flag", WIDTH'(overflow_err), WIDTH'(ERR_EXP));
    // Write blocked while full even with a simultaneous read.
    din = WIDTH'(99); wr_en = 1'b1; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0;
    check("fullrw_count", WIDTH'(data_count), 7);
    rd_en = 1'b1; repeat (7) tick(); rd_en = 1'b0;
    check("drain_empty", WIDTH'(empty), 1);
    check("drain_count", WIDTH'(data_count), 0);

    // Steady state at count 4 with concurrent read/write across pointer wrap.
    for (int i = 0; i < 4; i++) push(WIDTH'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      din = WIDTH'(8'h14 + i); wr_en = 1'b1; rd_en = 1'b1;
      exp_q.push_back(din);
      tick();
      check("rw_count", WIDTH'(data_count), 4);
    end
    wr_en = 1'b0;
    repeat (4) tick();
    rd_en = 1'b0;
    check("rw_empty", WIDTH'(empty), 1);

    // Pop on empty.
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("unf_empty", WIDTH'(empty), 1);
    check("unf_flag", WIDTH'(underflow_err), WIDTH'(ERR_EXP));
    check("unf_count", WIDTH'(data_count), 0);

    // Asynchronous reset at count 5; words are discarded, so not queued.
    for (int i = 0; i < 5; i++) begin
      din = WIDTH'(8'h40 + i); wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    check("pre_rst_count", WIDTH'(data_count), 5);
    #2 reset = 1'b0;
    #1;
    check("arst_empty", WIDTH'(empty), 1);
    check("arst_count", WIDTH'(data_count), 0);
    check("arst_dout", dout, 0);
    check("arst_unf", WIDTH'(underflow_err), 0);
    tick();
    reset = 1'b1;
    tick();
    push(WIDTH'(72'h55));
    check("post_rst_dout", dout, WIDTH'(72'h55));
    check("post_rst_count", WIDTH'(data_count), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tick();
    check("queue_drained", WIDTH'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
